fp_unpack_pipe: RTL and testbench

FP_UNPACK_PIPE -- requirements
Module: fp_unpack_pipe

---
 rtl/fp_unpack_pkg.sv | 30 +++
 rtl/fp_unpack_pipe_if.sv | 49 ++++
 rtl/fp_lzc.sv | 21 ++
 rtl/fp_unpack_pipe.sv | 211 +++++++++++++++++++++
 tb/tb_fp_unpack_pipe.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_unpack_pkg.sv
// fp_unpack_pkg -- shared constants for the floating-point operand unpacker.
//   * Bit positions of the one-hot class vector, {snan, qnan, inf, normal,
//     subnormal, zero} with snan in the MSB.
//   * One-hot class constants CLS_ZERO ... CLS_SNAN and the cls_t type.
//   * bias(): exponent bias 2^(exp_w-1)-1 for a given exponent field width.
package fp_unpack_pkg;

  localparam int CLS_W = 6;

  localparam int CLS_ZERO_BIT   = 0;
  localparam int CLS_SUB_BIT    = 1;
  localparam int CLS_NORMAL_BIT = 2;
  localparam int CLS_INF_BIT    = 3;
  localparam int CLS_QNAN_BIT   = 4;
  localparam int CLS_SNAN_BIT   = 5;

  typedef logic [CLS_W-1:0] cls_t;

  localparam cls_t CLS_ZERO   = cls_t'(1 << CLS_ZERO_BIT);
  localparam cls_t CLS_SUB    = cls_t'(1 << CLS_SUB_BIT);
  localparam cls_t CLS_NORMAL = cls_t'(1 << CLS_NORMAL_BIT);
  localparam cls_t CLS_INF    = cls_t'(1 << CLS_INF_BIT);
  localparam cls_t CLS_QNAN   = cls_t'(1 << CLS_QNAN_BIT);
  localparam cls_t CLS_SNAN   = cls_t'(1 << CLS_SNAN_BIT);

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_unpack_pipe_if.sv
// fp_unpack_pipe_if -- stream interface of the operand unpacker.
//   Input side : in_valid/in_ready handshake, packed operands in_a/in_b
//                ({sign, exp, frac}) and sideband in_tag.
//   Output side: out_valid/out_ready handshake, per-operand sign/exp/mant/cls,
//                out_tag and the pair-level nan/inf/zero/invalid flags.
//   modport master: the producer/consumer around the block (testbench side).
//   modport slave : the unpacker itself.
interface fp_unpack_pipe_if #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int TAG_W = 4
);
  import fp_unpack_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [EXP_W+MAN_W:0] in_a;
  logic [EXP_W+MAN_W:0] in_b;
  logic [TAG_W-1:0]     in_tag;

  logic                 out_valid;
  logic                 out_ready;
  logic                 sign_a;
  logic                 sign_b;
  logic [EXP_W+1:0]     exp_a;
  logic [EXP_W+1:0]     exp_b;
  logic [MAN_W:0]       mant_a;
  logic [MAN_W:0]       mant_b;
  cls_t                 cls_a;
  cls_t                 cls_b;
  logic [TAG_W-1:0]     out_tag;
  logic                 nan_flag;
  logic                 inf_flag;
  logic                 zero_flag;
  logic                 invalid_flag;

  modport master (
    output in_valid, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, sign_a, sign_b, exp_a, exp_b, mant_a, mant_b,
           cls_a, cls_b, out_tag, nan_flag, inf_flag, zero_flag, invalid_flag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, sign_a, sign_b, exp_a, exp_b, mant_a, mant_b,
           cls_a, cls_b, out_tag, nan_flag, inf_flag, zero_flag, invalid_flag
  );

endinterface

// File: rtl/fp_lzc.sv
// fp_lzc -- combinational leading-zero counter.
//   din   : W-bit input vector.
//   count : number of zeros above the highest set bit; W when din is all zero.
module fp_lzc #(
  parameter int W = 11
) (
  input  logic [W-1:0]           din,
  output logic [$clog2(W+1)-1:0] count
);

  localparam int CNT_W = $clog2(W + 1);

  // Scan upward so that the highest set bit is the last one to write count.
  always_comb begin
    count = CNT_W'(W);
    for (int i = 0; i < W; i++) begin
      if (din[i]) count = CNT_W'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_unpack_pipe.sv
// fp_unpack_pipe -- two-stage unpacker for a pair of IEEE-style operands.
//   clk : clock, all state on the rising edge.
//   rst : asynchronous active-high reset; empties both stages at once.
//   bus : fp_unpack_pipe_if.slave
//         in_valid/in_ready/in_a/in_b/in_tag   operand pair input
//         out_valid/out_ready                  result handshake
//         sign_*/exp_*/mant_*/cls_*            unpacked operands
//         out_tag, nan/inf/zero/invalid_flag   tag and pair-level flags
// Stage 1 holds the raw fields, the class and the leading-zero count of the
// fraction; stage 2 holds the normalised exponent/significand, flags and tag.
// Parameters: EXP_W >= 3, MAN_W >= 2, TAG_W >= 1.
module fp_unpack_pipe
  import fp_unpack_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  fp_unpack_pipe_if.slave  bus
);

  localparam int OP_W = 1 + EXP_W + MAN_W;
  localparam int XE_W = EXP_W + 2;
  localparam int LZ_W = $clog2(MAN_W + 2);

  // Handshake: each stage moves when empty or when the stage after it moves.
  logic s1_valid_reg;
  logic s2_valid_reg;
  logic adv1;
  logic adv2;
  logic accept;
  logic load2;

  assign adv2   = !s2_valid_reg || bus.out_ready;
  assign adv1   = !s1_valid_reg || adv2;
  assign accept = bus.in_valid && adv1;
  assign load2  = s1_valid_reg && adv2;

  assign bus.in_ready = adv1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
    end else begin
      if (adv1) s1_valid_reg <= bus.in_valid;
      if (adv2) s2_valid_reg <= s1_valid_reg;
    end
  end

  // Per-operand datapath, operand 0 = a, operand 1 = b.
  logic [1:0][OP_W-1:0]  op_in;
  logic [1:0]            s1_sign;
  logic [1:0][CLS_W-1:0] s1_cls;
  logic [1:0]            s2_sign;
  logic [1:0][XE_W-1:0]  s2_exp;
  logic [1:0][MAN_W:0]   s2_mant;
  logic [1:0][CLS_W-1:0] s2_cls;

  assign op_in[0] = bus.in_a;
  assign op_in[1] = bus.in_b;

  for (genvar gi = 0; gi < 2; gi++) begin : g_op
    logic [EXP_W-1:0] exp_field;
    logic [MAN_W-1:0] frac_field;
    cls_t             cls_next;
    logic [LZ_W-1:0]  lz_next;

    logic             s1_sign_reg;
    logic [EXP_W-1:0] s1_exp_reg;
    logic [MAN_W-1:0] s1_frac_reg;
    cls_t             s1_cls_reg;
    logic [LZ_W-1:0]  s1_lz_reg;

    logic [XE_W-1:0]  exp_next;
    logic [MAN_W:0]   mant_next;
    logic             s2_sign_reg;
    logic [XE_W-1:0]  s2_exp_reg;
    logic [MAN_W:0]   s2_mant_reg;
    cls_t             s2_cls_reg;

    assign exp_field  = op_in[gi][OP_W-2 -: EXP_W];
    assign frac_field = op_in[gi][MAN_W-1:0];

    always_comb begin
      cls_next = CLS_NORMAL;
      if (exp_field == '0) begin
        cls_next = (frac_field == '0) ? CLS_ZERO : CLS_SUB;
      end else if (exp_field == '1) begin
        if (frac_field == '0)           cls_next = CLS_INF;
        else if (frac_field[MAN_W-1])   cls_next = CLS_QNAN;
        else                            cls_next = CLS_SNAN;
      end
    end

    // Count over {0, frac}: for a subnormal this is the shift that puts the
    // first set bit into the hidden-bit position.
    fp_lzc #(.W(MAN_W + 1)) u_lzc (
      .din   ({1'b0, frac_field}),
      .count (lz_next)
    );

    always_ff @(posedge clk) begin
      if (accept) begin
        s1_sign_reg <= op_in[gi][OP_W-1];
        s1_exp_reg  <= exp_field;
        s1_frac_reg <= frac_field;
        s1_cls_reg  <= cls_next;
        s1_lz_reg   <= lz_next;
      end
    end

    // Hidden bit comes only from the class; inf/NaN keep the raw fraction
    // and exponent field.
    always_comb begin
      mant_next = {1'b0, s1_frac_reg};
      exp_next  = XE_W'(s1_exp_reg);
      if (s1_cls_reg[CLS_NORMAL_BIT]) begin
        mant_next = {1'b1, s1_frac_reg};
      end else if (s1_cls_reg[CLS_SUB_BIT]) begin
        mant_next = {1'b0, s1_frac_reg} << s1_lz_reg;
        exp_next  = XE_W'(1) - XE_W'(s1_lz_reg);
      end else if (s1_cls_reg[CLS_ZERO_BIT]) begin
        mant_next = '0;
        exp_next  = '0;
      end
    end

    always_ff @(posedge clk) begin
      if (load2) begin
        s2_sign_reg <= s1_sign_reg;
        s2_exp_reg  <= exp_next;
        s2_mant_reg <= mant_next;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)        s2_cls_reg <= '0;
      else if (load2) s2_cls_reg <= s1_cls_reg;
    end

    assign s1_sign[gi] = s1_sign_reg;
    assign s1_cls[gi]  = s1_cls_reg;
    assign s2_sign[gi] = s2_sign_reg;
    assign s2_exp[gi]  = s2_exp_reg;
    assign s2_mant[gi] = s2_mant_reg;
    assign s2_cls[gi]  = s2_cls_reg;
  end

  // Pair-level flags, computed from the stage-1 classes.
  logic nan_next;
  logic inf_next;
  logic zero_next;
  logic invalid_next;

  always_comb begin
    nan_next     = s1_cls[0][CLS_QNAN_BIT] || s1_cls[0][CLS_SNAN_BIT] ||
                   s1_cls[1][CLS_QNAN_BIT] || s1_cls[1][CLS_SNAN_BIT];
    inf_next     = s1_cls[0][CLS_INF_BIT] || s1_cls[1][CLS_INF_BIT];
    zero_next    = s1_cls[0][CLS_ZERO_BIT] && s1_cls[1][CLS_ZERO_BIT];
    // Opposite-signed infinities are flagged even though no operation is
    // known here; the consumer is assumed to be an adder.
    invalid_next = s1_cls[0][CLS_SNAN_BIT] || s1_cls[1][CLS_SNAN_BIT] ||
                   (s1_cls[0][CLS_INF_BIT] && s1_cls[1][CLS_INF_BIT] &&
                    (s1_sign[0] != s1_sign[1]));
  end

  logic             nan_reg;
  logic             inf_reg;
  logic             zero_reg;
  logic             invalid_reg;
  logic [TAG_W-1:0] s1_tag_reg;
  logic [TAG_W-1:0] s2_tag_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nan_reg     <= 1'b0;
      inf_reg     <= 1'b0;
      zero_reg    <= 1'b0;
      invalid_reg <= 1'b0;
    end else if (load2) begin
      nan_reg     <= nan_next;
      inf_reg     <= inf_next;
      zero_reg    <= zero_next;
      invalid_reg <= invalid_next;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) s1_tag_reg <= bus.in_tag;
    if (load2)  s2_tag_reg <= s1_tag_reg;
  end

  assign bus.out_valid    = s2_valid_reg;
  assign bus.sign_a       = s2_sign[0];
  assign bus.sign_b       = s2_sign[1];
  assign bus.exp_a        = s2_exp[0];
  assign bus.exp_b        = s2_exp[1];
  assign bus.mant_a       = s2_mant[0];
  assign bus.mant_b       = s2_mant[1];
  assign bus.cls_a        = s2_cls[0];
  assign bus.cls_b        = s2_cls[1];
  assign bus.out_tag      = s2_tag_reg;
  assign bus.nan_flag     = nan_reg;
  assign bus.inf_flag     = inf_reg;
  assign bus.zero_flag    = zero_reg;
  assign bus.invalid_flag = invalid_reg;

endmodule

// File: tb/tb_fp_unpack_pipe.sv
// tb_fp_unpack_pipe -- self-checking bench for fp_unpack_pipe.
// A half-precision instance is checked every cycle against a value-level
// model (class from the field values, subnormals normalised by repeated
// doubling, latency/occupancy tracked with a queue of accepted pairs).
// A single-precision instance gets the directed 1.0 / smallest-subnormal check.
module tb_fp_unpack_pipe;
  import fp_unpack_pkg::*;

  localparam logic [5:0] C_ZERO = 6'b000001;
  localparam logic [5:0] C_SUB  = 6'b000010;
  localparam logic [5:0] C_NORM = 6'b000100;
  localparam logic [5:0] C_INF  = 6'b001000;
  localparam logic [5:0] C_QNAN = 6'b010000;
  localparam logic [5:0] C_SNAN = 6'b100000;

  typedef struct packed {
    logic        sign;
    logic [6:0]  exp;
    logic [10:0] mant;
    logic [5:0]  cls;
  } op_t;

  typedef struct {
    op_t        a;
    op_t        b;
    logic [3:0] tag;
    logic [3:0] flags;   // {nan, inf, zero, invalid}
    int         acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   sent;
  logic last_acc;
  exp_t q[$];

  always #5 clk = ~clk;

  fp_unpack_pipe_if #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) bus ();
  fp_unpack_pipe_if #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) bus32 ();

  fp_unpack_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  fp_unpack_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) u_dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  function automatic op_t model_op(input logic [15:0] x);
    op_t r;
    int  e;
    int  f;
    int  m;
    int  ex;
    e = int'(x[14:10]);
    f = int'(x[9:0]);
    r.sign = x[15];
    if (e == 0 && f == 0) begin
      r.cls = C_ZERO; r.exp = 7'd0; r.mant = 11'd0;
    end else if (e == 0) begin
      m = f; ex = 1;
      while (m < 1024) begin
        m = m * 2;
        ex = ex - 1;
      end
      r.cls = C_SUB; r.exp = 7'(ex); r.mant = 11'(m);
    end else if (e == 31) begin
      r.exp = 7'd31; r.mant = 11'(f);
      if (f == 0)        r.cls = C_INF;
      else if (f >= 512) r.cls = C_QNAN;
      else               r.cls = C_SNAN;
    end else begin
      r.cls = C_NORM; r.exp = 7'(e); r.mant = 11'(1024 + f);
    end
    return r;
  endfunction

  function automatic exp_t model_pair(input logic [15:0] a, input logic [15:0] b,
                                      input logic [3:0] tag);
    exp_t r;
    r.a = model_op(a);
    r.b = model_op(b);
    r.tag = tag;
    r.acc = 0;
    r.flags[3] = (r.a.cls == C_QNAN) || (r.a.cls == C_SNAN) ||
                 (r.b.cls == C_QNAN) || (r.b.cls == C_SNAN);
    r.flags[2] = (r.a.cls == C_INF) || (r.b.cls == C_INF);
    r.flags[1] = (r.a.cls == C_ZERO) && (r.b.cls == C_ZERO);
    r.flags[0] = (r.a.cls == C_SNAN) || (r.b.cls == C_SNAN) ||
                 ((r.a.cls == C_INF) && (r.b.cls == C_INF) && (r.a.sign != r.b.sign));
    return r;
  endfunction

  function automatic logic [15:0] rand_op();
    logic [4:0] e;
    logic [9:0] f;
    int         k;
    k = int'($urandom_range(5, 0));
    f = 10'($urandom);
    case (k)
      0: begin e = 5'd0; f = 10'd0; end
      1: begin
        e = 5'd0;
        f = f >> $urandom_range(9, 0);
        if (f == 10'd0) f = 10'd1;
      end
      2: e = 5'($urandom_range(30, 1));
      3: begin e = 5'h1F; f = 10'd0; end
      4: begin e = 5'h1F; f[9] = 1'b1; end
      default: begin
        e = 5'h1F; f[9] = 1'b0;
        if (f == 10'd0) f = 10'd1;
      end
    endcase
    return {1'($urandom), e, f};
  endfunction

  // One clock cycle: check outputs at the falling edge, then apply the
  // model's view of what transferred at the rising edge.
  task automatic cycle();
    exp_t e;
    logic exp_valid;
    logic exp_ready;
    logic acc;
    logic fire;
    @(negedge clk);
    exp_valid = (q.size() > 0) && (cyc >= q[0].acc + 2);
    exp_ready = !((q.size() == 2) && !bus.out_ready);
    chk("in_ready", 64'(bus.in_ready), 64'(exp_ready));
    chk("out_valid", 64'(bus.out_valid), 64'(exp_valid));
    if (exp_valid && bus.out_valid) begin
      chk("out_tag", 64'(bus.out_tag), 64'(q[0].tag));
      chk("op_a", 64'({bus.sign_a, bus.exp_a, bus.mant_a, bus.cls_a}), 64'(q[0].a));
      chk("op_b", 64'({bus.sign_b, bus.exp_b, bus.mant_b, bus.cls_b}), 64'(q[0].b));
      chk("flags", 64'({bus.nan_flag, bus.inf_flag, bus.zero_flag, bus.invalid_flag}),
          64'(q[0].flags));
    end
    acc  = bus.in_valid && exp_ready;
    fire = exp_valid && bus.out_ready;
    e = model_pair(bus.in_a, bus.in_b, bus.in_tag);
    e.acc = cyc;
    @(posedge clk);
    if (fire) begin
      $display("txn out tag=%h cls_a=%b cls_b=%b flags=%b", q[0].tag, q[0].a.cls,
               q[0].b.cls, q[0].flags);
      void'(q.pop_front());
    end
    if (acc) q.push_back(e);
    cyc++;
    last_acc = acc;
    #1;
  endtask

  task automatic directed(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] flags);
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_tag = 4'hD;
    cycle();
    bus.in_valid = 1'b0;
    cycle();
    chk({name, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({name, "_flags"}, 64'({bus.nan_flag, bus.inf_flag, bus.zero_flag, bus.invalid_flag}),
        64'(flags));
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_tag = '0; bus.out_ready = 1'b1;
    bus32.in_valid = 1'b0; bus32.in_a = '0; bus32.in_b = '0; bus32.in_tag = '0;
    bus32.out_ready = 1'b1;

    // Reset state.
    @(posedge clk); #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_flags_cls", 64'({bus.nan_flag, bus.inf_flag, bus.zero_flag, bus.invalid_flag,
                              bus.cls_a, bus.cls_b}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1.0 and smallest subnormal, both precisions, accepted on the first edge.
    bus.in_valid = 1'b1; bus.in_a = 16'h3C00; bus.in_b = 16'h0001; bus.in_tag = 4'h1;
    bus32.in_valid = 1'b1; bus32.in_a = 32'h3F800000; bus32.in_b = 32'h00000001;
    bus32.in_tag = 4'h1;
    cycle();
    bus.in_valid = 1'b0; bus32.in_valid = 1'b0;
    cycle();
    chk("h_valid", 64'(bus.out_valid), 64'd1);
    chk("h_exp_a", 64'(bus.exp_a), 64'(bias(5)));
    chk("h_mant_a", 64'(bus.mant_a), 64'h400);
    chk("h_cls_a", 64'(bus.cls_a), 64'(C_NORM));
    chk("h_exp_b", 64'(bus.exp_b), 64'(7'h77));
    chk("h_mant_b", 64'(bus.mant_b), 64'h400);
    chk("h_cls_b", 64'(bus.cls_b), 64'(C_SUB));
    chk("s_valid", 64'(bus32.out_valid), 64'd1);
    chk("s_exp_a", 64'(bus32.exp_a), 64'(bias(8)));
    chk("s_mant_a", 64'(bus32.mant_a), 64'h800000);
    chk("s_exp_b", 64'(bus32.exp_b), 64'(10'h3EA));
    chk("s_mant_b", 64'(bus32.mant_b), 64'h800000);
    chk("s_cls_b", 64'(bus32.cls_b), 64'(C_SUB));

    // Infinity / NaN / zero flag cases.
    directed("inf_opp", 16'h7C00, 16'hFC00, 4'b0101);
    directed("inf_same", 16'h7C00, 16'h7C00, 4'b0100);
    directed("nan", 16'h7E00, 16'h7D00, 4'b1001);
    chk("nan_cls_a", 64'(bus.cls_a), 64'(C_QNAN));
    chk("nan_cls_b", 64'(bus.cls_b), 64'(C_SNAN));
    directed("zero", 16'h0000, 16'h8000, 4'b0010);
    cycle();

    // Eight pairs with distinct tags under a randomly stalling consumer.
    sent = 0;
    for (int c = 0; c < 200 && sent < 8; c++) begin
      bus.out_ready = 1'($urandom);
      bus.in_valid = 1'b1; bus.in_a = rand_op(); bus.in_b = rand_op();
      bus.in_tag = 4'(sent);
      cycle();
      if (last_acc) sent++;
    end

    // Longer random stream with bubbles on both sides.
    sent = 0;
    for (int c = 0; c < 2000 && sent < 120; c++) begin
      bus.out_ready = ($urandom_range(3, 0) != 0);
      bus.in_valid = ($urandom_range(3, 0) != 0);
      bus.in_a = rand_op(); bus.in_b = rand_op(); bus.in_tag = 4'(sent);
      cycle();
      if (last_acc) sent++;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) cycle();

    // Reset with two pairs in flight.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_a = 16'h4000; bus.in_b = 16'h0200; bus.in_tag = 4'h5;
    cycle();
    bus.in_a = 16'hC400; bus.in_b = 16'h7C00; bus.in_tag = 4'h6;
    cycle();
    bus.in_valid = 1'b0;
    cycle();
    chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("async_rst_flags", 64'({bus.nan_flag, bus.inf_flag, bus.zero_flag, bus.invalid_flag,
                                bus.cls_a, bus.cls_b}), 64'd0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) cycle();
    bus.in_valid = 1'b1; bus.in_a = 16'h3555; bus.in_b = 16'h0123; bus.in_tag = 4'h9;
    cycle();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 4; c++) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
